// File: rtl/obm.sv
// obm: output buffer manager. Queues scheduler metadata, requests each packet from the data
// cache, forwards its beats to the port and frees the buffer ID. Optional macro: OBM_TIMEOUT_EN.
module obm #(
  parameter int MD_DEPTH_LOG2 = 2
`ifdef OBM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [23:0]  in_obm_md,
  input  logic         in_obm_md_wr,
  output logic         out_obm_md_alf,
  output logic [7:0]   out_obm_rd_ID,
  output logic         out_obm_rd_ID_wr,
  input  logic [133:0] in_obm_data,
  input  logic         in_obm_data_wr,
  input  logic         in_obm_port_alf,
  output logic [133:0] out_obm_data,
  output logic         out_obm_data_wr,
  output logic         out_obm_valid,
  output logic         out_obm_valid_wr,
  output logic [15:0]  out_obm_pkt_meta,
  output logic [7:0]   out_obm_free_ID,
  output logic         out_obm_free_ID_wr,
  output logic [15:0]  out_obm_tx_count,
  output logic [7:0]   out_obm_err_count,
  output logic [1:0]   dbg_state
);
  localparam int DEPTH = 1 << MD_DEPTH_LOG2;
  localparam int CW = MD_DEPTH_LOG2 + 1;
  localparam logic [1:0] HDR_HEAD = 2'b01;
  localparam logic [1:0] HDR_TAIL = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, TRANS = 2'd2} state_t;
  state_t state, state_nxt;

  logic [23:0]              md_mem [DEPTH];
  logic [MD_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]            md_cnt;
  logic                     md_empty, md_full, md_push, md_pop, md_drop;
  logic [23:0]              md_head;
  logic [1:0]               hdr;
  logic                     fwd, tail, bad_head, timeout;
  logic [1:0]               err_add;
  logic [8:0]               err_sum;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  assign md_empty       = (md_cnt == '0);
  assign md_full        = (md_cnt == CW'(DEPTH));
  assign md_push        = in_obm_md_wr && (!md_full || md_pop);
  assign md_drop        = in_obm_md_wr && md_full && !md_pop;
  assign md_head        = md_mem[rd_ptr];
  assign out_obm_md_alf = (md_cnt >= CW'(DEPTH - 1));
  assign hdr            = in_obm_data[133:132];
  assign dbg_state      = state;

  always_ff @(posedge clk) begin
    if (md_push) md_mem[wr_ptr] <= in_obm_md;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      md_cnt <= '0;
    end else begin
      if (md_push) wr_ptr <= wr_ptr + MD_DEPTH_LOG2'(1);
      if (md_pop)  rd_ptr <= rd_ptr + MD_DEPTH_LOG2'(1);
      case ({md_push, md_pop})
        2'b10:   md_cnt <= md_cnt + CW'(1);
        2'b01:   md_cnt <= md_cnt - CW'(1);
        default: md_cnt <= md_cnt;
      endcase
    end
  end

`ifdef OBM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wait_cnt;

  // Held at zero outside WAIT, so it restarts on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wait_cnt <= '0;
    else if (state != WAIT)        wait_cnt <= '0;
    else if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + TW'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    md_pop    = 1'b0;
    fwd       = 1'b0;
    tail      = 1'b0;
    bad_head  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (!md_empty && !in_obm_port_alf) begin
          md_pop    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (in_obm_data_wr && hdr == HDR_HEAD) begin
          fwd       = 1'b1;
          state_nxt = TRANS;
        end else begin
          bad_head = in_obm_data_wr;
`ifdef OBM_TIMEOUT_EN
          if (wait_cnt == WAIT_LIMIT) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
          end
`endif
        end
      end
      TRANS: begin
        // Stray head headers mid-packet are passed through; only a tail ends the packet.
        if (in_obm_data_wr) begin
          fwd = 1'b1;
          if (hdr == HDR_TAIL) begin
            tail      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign err_add = 2'(md_drop) + 2'(bad_head) + 2'(timeout);
  assign err_sum = {1'b0, out_obm_err_count} + {7'd0, err_add};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_obm_rd_ID      <= '0;
      out_obm_rd_ID_wr   <= 1'b0;
      out_obm_pkt_meta   <= '0;
      out_obm_data       <= '0;
      out_obm_data_wr    <= 1'b0;
      out_obm_valid      <= 1'b0;
      out_obm_valid_wr   <= 1'b0;
      out_obm_free_ID    <= '0;
      out_obm_free_ID_wr <= 1'b0;
      out_obm_tx_count   <= '0;
      out_obm_err_count  <= '0;
    end else begin
      out_obm_rd_ID_wr <= md_pop;
      if (md_pop) begin
        out_obm_rd_ID    <= md_head[7:0];
        out_obm_pkt_meta <= md_head[23:8];
      end
      out_obm_data_wr <= fwd;
      if (fwd) out_obm_data <= in_obm_data;
      out_obm_valid      <= tail;
      out_obm_valid_wr   <= tail;
      out_obm_free_ID_wr <= tail || timeout;
      if (tail || timeout) out_obm_free_ID <= out_obm_rd_ID;
      if (tail) out_obm_tx_count <= out_obm_tx_count + 16'd1;
      out_obm_err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end
endmodule
